custom_axi_ip_regs: RTL

AXI4-Lite responder and register file on the software side of the custom IP's register-to-hardware interface. Software writes an operand and a start bit; the block drives the operand and a one-cycle enable pulse to the IP. It captures the IP's write-back (data, write enable, status) into read-only registers that software polls. Sits between the AXI-Lite interconnect and the processing core.

---
 rtl/custom_axi_ip_regs.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register file driving a custom IP core: operand + start pulse out, result/status in.
// Optional interrupt output and CTRL.IE bit when CUSTOM_AXI_IP_REGS_IRQ_EN is defined.
module custom_axi_ip_regs #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic [3:0]            s_wstrb_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [DATA_WIDTH-1:0] ipreg_data_o,
  output logic                  enable_o,
  input  logic [DATA_WIDTH-1:0] hw_data_i,
  input  logic                  hw_wen_i,
  input  logic [1:0]            hw_status_i,
`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  output logic                  irq_o,
`endif
  output logic                  dbg_wr_state,
  output logic                  dbg_rd_state
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("custom_axi_ip_regs: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 5) begin : g_bad_addr_width
    $error("custom_axi_ip_regs: ADDR_WIDTH must be at least 5");
  end

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both 1;
  // a source keeps valid and its payload stable until that edge, ready may change freely.

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] VERSION     = 32'h0001_0000;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  wr_state_e   wr_state;
  rd_state_e   rd_state;

  logic        aw_held, w_held;
  logic [2:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        aw_hs, w_hs, wr_fire, wr_mapped;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic [31:0] data_in, result;
  logic        done, ovr, ie;
  logic        start_req, start_ok, start_drop, w1c_en;

  logic [31:0] rd_val;
  logic        rd_ok;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr_i[1:0], s_araddr_i[1:0]};

  assign aw_hs = s_awvalid_i & s_awready_o;
  assign w_hs  = s_wvalid_i & s_wready_o;

  // A beat accepted this cycle is used directly so the update happens on its own edge.
  always_comb begin
    wr_idx    = aw_held ? aw_idx_q : s_awaddr_i[4:2];
    wr_data   = w_held ? w_data_q : s_wdata_i;
    wr_strb   = w_held ? w_strb_q : s_wstrb_i;
    wr_fire   = (wr_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
    wr_mapped = (wr_idx <= 3'd4);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state    <= W_IDLE;
      s_awready_o <= 1'b0;
      s_wready_o  <= 1'b0;
      s_bvalid_o  <= 1'b0;
      s_bresp_o   <= RESP_OKAY;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx_q    <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_fire) begin
            s_bvalid_o  <= 1'b1;
            s_bresp_o   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            s_awready_o <= 1'b0;
            s_wready_o  <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            wr_state    <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held     <= 1'b1;
              aw_idx_q    <= s_awaddr_i[4:2];
              s_awready_o <= 1'b0;
            end else begin
              s_awready_o <= ~aw_held;
            end
            if (w_hs) begin
              w_held     <= 1'b1;
              w_data_q   <= s_wdata_i;
              w_strb_q   <= s_wstrb_i;
              s_wready_o <= 1'b0;
            end else begin
              s_wready_o <= ~w_held;
            end
          end
        end
        W_RESP: begin
          if (s_bready_i) begin
            s_bvalid_o  <= 1'b0;
            s_awready_o <= 1'b1;
            s_wready_o  <= 1'b1;
            wr_state    <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    start_req  = wr_fire & (wr_idx == 3'd0) & wr_strb[0] & wr_data[0];
    start_ok   = start_req & (hw_status_i == 2'd0);
    start_drop = start_req & (hw_status_i != 2'd0);
    w1c_en     = wr_fire & (wr_idx == 3'd3) & wr_strb[1];
  end

  // Hardware set events take priority over a coincident software clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_in  <= '0;
      result   <= '0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      enable_o <= 1'b0;
    end else begin
      enable_o <= start_ok;
      if (wr_fire && wr_idx == 3'd1) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) data_in[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      if (hw_wen_i) result <= hw_data_i;
      done <= hw_wen_i | (done & ~(w1c_en & wr_data[8]));
      ovr  <= start_drop | (ovr & ~(w1c_en & wr_data[9]));
    end
  end

`ifdef CUSTOM_AXI_IP_REGS_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_fire && wr_idx == 3'd0 && wr_strb[0]) ie <= wr_data[1];
      irq_o <= ie & (done | ovr);
    end
  end
`else
  assign ie = 1'b0;
`endif

  assign ipreg_data_o = data_in;

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case (s_araddr_i[4:2])
      3'd0:    rd_val = {30'd0, ie, 1'b0};
      3'd1:    rd_val = data_in;
      3'd2:    rd_val = result;
      3'd3:    rd_val = {22'd0, ovr, done, 6'd0, hw_status_i};
      3'd4:    rd_val = VERSION;
      default: rd_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state    <= R_IDLE;
      s_arready_o <= 1'b0;
      s_rvalid_o  <= 1'b0;
      s_rdata_o   <= '0;
      s_rresp_o   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_arvalid_i && s_arready_o) begin
            s_rdata_o   <= rd_val;
            s_rresp_o   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            s_rvalid_o  <= 1'b1;
            s_arready_o <= 1'b0;
            rd_state    <= R_DATA;
          end else begin
            s_arready_o <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready_i) begin
            s_rvalid_o  <= 1'b0;
            s_arready_o <= 1'b1;
            rd_state    <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;

endmodule
